hps_design_pll_rst_seq: RTL

- Reset/lock sequencer on the free-running reference clock of the HPS fabric PLL.
- Drives the PLL `rst` pin: power-up pulse, plus re-pulse on lock timeout or lock loss.
- Consumes the PLL `locked` output asynchronously, qualifies it as stable, then releases the fabric reset domains in staggered order.
- Sits between the board reset input and the PLL; its outputs feed the per-domain reset synchronizers downstream.

---
 rtl/hps_design_rst_pkg.sv | 28 ++
 rtl/hps_design_sync_bit.sv | 23 ++
 rtl/hps_design_pll_rst_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hps_design_rst_pkg.sv
// Shared types and helpers for the HPS fabric PLL reset/lock sequencer.
package hps_design_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        LOCK_STABLE,
        RELEASE,
        RUN
    } seq_state_e;

    localparam logic [7:0] CNT_SAT = 8'hFF;

    // The one shared counter must be able to hold the largest interval it times.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hps_design_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by async reset.
module hps_design_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hps_design_pll_rst_seq.sv
// PLL reset pulse generator and lock qualifier; releases fabric resets in
// staggered index order once lock has been stable, and re-runs on loss.
module hps_design_pll_rst_seq
    import hps_design_rst_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int NUM_RESETS          = 2,
    parameter int STAGGER_CYCLES      = 8,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic                  pll_rst,
    output logic [NUM_RESETS-1:0] reset_out_n,
    output logic                  ready,
    output logic [7:0]            lock_lost_cnt,
    output logic [7:0]            timeout_cnt
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES, NUM_RESETS * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_END  = CNT_W'(NUM_RESETS * STAGGER_CYCLES);

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_nxt;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;
    logic [7:0]            lost_q, lost_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  locked_s;

    hps_design_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '0;
            ready_q   <= 1'b0;
            lost_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pll_rst_d = pll_rst_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        lost_d    = lost_q;
        tmo_d     = tmo_q;
        cnt_nxt   = cnt_q + 1'b1;

        case (state_q)
            PLL_RST: begin
                pll_rst_d = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = LOCK_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    tmo_d     = sat_inc(tmo_q);
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            LOCK_STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            RELEASE, RUN: begin
                // Lock loss outranks a soft request, so a coincident pair still counts.
                if (!locked_s || soft_reset_req) begin
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    rst_out_d = '0;
                    ready_d   = 1'b0;
                    if (!locked_s) lost_d = sat_inc(lost_q);
                end else if (state_q == RELEASE) begin
                    cnt_d = cnt_nxt;
                    for (int i = 0; i < NUM_RESETS; i++) begin
                        if (cnt_nxt == CNT_W'((i + 1) * STAGGER_CYCLES)) rst_out_d[i] = 1'b1;
                    end
                    if (cnt_nxt == RELEASE_END) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    assign pll_rst       = pll_rst_q;
    assign reset_out_n   = rst_out_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = lost_q;
    assign timeout_cnt   = tmo_q;

endmodule
